// File: rtl/delivery_generator_if.sv
// Ball-event bundle from the delivery generator to the game block.
// One delivery is presented on ball_* together with a single-cycle ball_valid.
interface delivery_generator_if;
  logic       ball_valid;
  logic [2:0] ball_runs;
  logic       ball_wicket;
  logic       ball_extra;

  modport master (
    output ball_valid,
    output ball_runs,
    output ball_wicket,
    output ball_extra
  );

  modport slave (
    input ball_valid,
    input ball_runs,
    input ball_wicket,
    input ball_extra
  );
endinterface

// File: rtl/delivery_generator.sv
// Debounced push-button to ball-event converter: one pseudo-random delivery
// (runs / wicket / wide) per clean press while the innings is live.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a debounced press with enable high
// ROLL  | sample captured; decode into the ball_* registers
// OUT   | ball_valid high for this single cycle
// HOLD  | waiting for button release; further presses are dropped
module delivery_generator #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                 clk_fpga,
  input  logic                 reset,
  input  logic                 btnU,
  input  logic                 enable,
  delivery_generator_if.master ball
);

  localparam int              CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     SEED    = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]     TAPS    = 16'hB400;

  typedef enum logic [1:0] {IDLE, ROLL, OUT, HOLD} state_t;

  state_t           state, state_nxt;
  logic             btn_m, btn_s;
  logic             btn_d, btn_d_q;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic [15:0]      lfsr;
  logic [3:0]       sample;
  logic             capture, load_ball, valid;
  logic [2:0]       dec_runs, runs_q;
  logic             dec_wicket, dec_extra, wicket_q, extra_q;

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      btn_m <= btnU;
      btn_s <= btn_m;
    end
  end

  // Level must differ from btn_d for DEBOUNCE_CYCLES consecutive cycles to flip it
  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      btn_d   <= 1'b0;
      btn_d_q <= 1'b0;
    end else begin
      btn_d_q <= btn_d;
      if (btn_s == btn_d) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        btn_d <= btn_s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = btn_d & ~btn_d_q;

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & TAPS);
    end
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    load_ball = 1'b0;
    valid     = 1'b0;
    case (state)
      IDLE: begin
        if (press && enable) begin
          state_nxt = ROLL;
          capture   = 1'b1;
        end
      end
      ROLL: begin
        load_ball = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        valid     = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (!btn_d) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dec_runs   = 3'd0;
    dec_wicket = 1'b0;
    dec_extra  = 1'b0;
    case (sample)
      4'd0, 4'd1, 4'd2, 4'd3: dec_runs = 3'd0;
      4'd4, 4'd5, 4'd6, 4'd7: dec_runs = 3'd1;
      4'd8, 4'd9:             dec_runs = 3'd2;
      4'd10:                  dec_runs = 3'd3;
      4'd11, 4'd12:           dec_runs = 3'd4;
      4'd13:                  dec_runs = 3'd6;
      4'd14:                  dec_wicket = 1'b1;
      default: begin
        dec_extra = 1'b1;
        dec_runs  = 3'd1;
      end
    endcase
  end

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      sample   <= 4'd0;
      runs_q   <= 3'd0;
      wicket_q <= 1'b0;
      extra_q  <= 1'b0;
    end else begin
      if (capture) sample <= lfsr[3:0];
      if (load_ball) begin
        runs_q   <= dec_runs;
        wicket_q <= dec_wicket;
        extra_q  <= dec_extra;
      end
    end
  end

  assign ball.ball_valid  = valid;
  assign ball.ball_runs   = runs_q;
  assign ball.ball_wicket = wicket_q;
  assign ball.ball_extra  = extra_q;

endmodule
